// File: rtl/hexplay_capture_pkg.sv
// ============================================================================
// hexplay_capture_pkg
// Shared widths and the output-register state type for hexplay_capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hexplay_capture_pkg;

  localparam int NDIG    = 8;
  localparam int DIG_W   = 4;
  localparam int AN_W    = 3;
  localparam int FRAME_W = 32;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

`default_nettype wire

// File: rtl/hexplay_capture_stable_filter.sv
// ============================================================================
// hexplay_stable_filter
// Input register plus run-length stability filter (HEXPLAY_CAPTURE_FILTER_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module hexplay_stable_filter
  import hexplay_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AN_W-1:0]  an_in,
  input  logic [DIG_W-1:0] data_in,
  output logic             accept,
  output logic [AN_W-1:0]  acc_an,
  output logic [DIG_W-1:0] acc_data
);

  logic [AN_W-1:0]  a_q;
  logic [DIG_W-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= an_in;
      d_q <= data_in;
    end
  end

`ifdef HEXPLAY_CAPTURE_FILTER_EN
  localparam logic [15:0] STABLE_LEN = 16'(STABLE_CYCLES);

  logic [15:0] run_len;
  logic [15:0] run_next;
  logic        changed;

  // Accept fires on the edge where the run length arrives at STABLE_LEN, so the
  // pair being registered on that edge is the one written.
  always_comb begin
    changed  = {an_in, data_in} != {a_q, d_q};
    run_next = run_len;
    if (changed)
      run_next = 16'd1;
    else if (run_len < STABLE_LEN)
      run_next = run_len + 16'd1;
    accept = (run_next == STABLE_LEN) && (changed || (run_len != STABLE_LEN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      run_len <= '0;
    else
      run_len <= run_next;
  end

  assign acc_an   = an_in;
  assign acc_data = data_in;
`else
  assign accept   = 1'b1;
  assign acc_an   = a_q;
  assign acc_data = d_q;
`endif

endmodule

`default_nettype wire

// File: rtl/hexplay_capture.sv
// ============================================================================
// hexplay_capture
// Rebuilds a scanned hex-display bus into 32-bit frames on a valid/ready port.
// Stability filter enabled by macro HEXPLAY_CAPTURE_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hexplay_capture
  import hexplay_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AN_W-1:0]    an_in,
  input  logic [DIG_W-1:0]   data_in,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [NDIG-1:0]    digit_seen,
  output logic               overrun
);

  logic             accept;
  logic [AN_W-1:0]  acc_an;
  logic [DIG_W-1:0] acc_data;

  hexplay_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .an_in    (an_in),
    .data_in  (data_in),
    .accept   (accept),
    .acc_an   (acc_an),
    .acc_data (acc_data)
  );

  out_state_t         state, state_next;
  logic [FRAME_W-1:0] shadow, shadow_next, shadow_upd, frame_next;
  logic [NDIG-1:0]    seen_next, seen_upd;
  logic               overrun_next, complete;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      shadow     <= '0;
      digit_seen <= '0;
      frame_data <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      shadow     <= shadow_next;
      digit_seen <= seen_next;
      frame_data <= frame_next;
      overrun    <= overrun_next;
    end
  end

  // Completion sees the shadow including the nibble written on the same edge.
  always_comb begin
    shadow_upd = shadow;
    shadow_upd[{acc_an, 2'b00} +: DIG_W] = acc_data;
    seen_upd     = digit_seen | (8'(1) << acc_an);
    complete     = accept && (seen_upd == '1);
    shadow_next  = shadow;
    seen_next    = digit_seen;
    frame_next   = frame_data;
    state_next   = state;
    overrun_next = 1'b0;
    if (accept) begin
      shadow_next = shadow_upd;
      seen_next   = seen_upd;
    end
    case (state)
      EMPTY: begin
        if (complete) begin
          frame_next = shadow_upd;
          seen_next  = '0;
          state_next = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          seen_next = '0;
          if (frame_ready)
            frame_next = shadow_upd;
          else
            overrun_next = 1'b1;
        end else if (frame_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign frame_valid = (state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_hexplay_capture.sv
// Randomized and directed bench for hexplay_capture against a frame-level model.
`default_nettype none
`timescale 1ns/1ps

module tb_hexplay_capture;

  localparam int S = 16;
`ifdef HEXPLAY_CAPTURE_FILTER_EN
  localparam int H   = 40;
  localparam int LAT = S;
`else
  localparam int H   = 1;
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  an = '0;
  logic [3:0]  dat = '0;
  logic        ready = 1'b0;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic [7:0]  digit_seen;
  logic        overrun;

  hexplay_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an),
    .data_in     (dat),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (ready),
    .digit_seen  (digit_seen),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: registered pair, run count, shadow, output slot.
  logic [2:0]  m_a;
  logic [3:0]  m_d;
  int          m_run;
  logic [31:0] m_shadow, m_frame;
  logic [7:0]  m_seen;
  logic        m_valid, m_ovr;

  int          obs_valid, obs_ovr;
  logic [31:0] obs_frame;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task model_edge();
    logic       acc, done;
    logic [2:0] pa;
    logic [3:0] pd;
    if (!rst_n) begin
      m_a = '0; m_d = '0; m_run = 0; m_shadow = '0; m_seen = '0;
      m_frame = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
`ifdef HEXPLAY_CAPTURE_FILTER_EN
    if ({an, dat} == {m_a, m_d}) m_run++;
    else m_run = 1;
    acc = (m_run == S);
    pa = an; pd = dat;
`else
    acc = 1'b1;
    pa = m_a; pd = m_d;
`endif
    m_a = an; m_d = dat;
    m_ovr = 1'b0;
    done = 1'b0;
    if (acc) begin
      m_shadow[pa*4 +: 4] = pd;
      m_seen[pa] = 1'b1;
      if (m_seen == 8'hFF) begin
        done = 1'b1;
        m_seen = '0;
        if (!m_valid || ready) begin
          m_frame = m_shadow;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (!done && m_valid && ready) m_valid = 1'b0;
  endtask

  task step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", {31'd0, frame_valid}, {31'd0, m_valid});
    chk("seen", {24'd0, digit_seen}, {24'd0, m_seen});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("frame", frame_data, m_frame);
    obs_valid += int'(frame_valid);
    obs_ovr   += int'(overrun);
    if (frame_valid) obs_frame = frame_data;
  endtask

  task do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    obs_valid = 0; obs_ovr = 0; obs_frame = '0;
  endtask

  task automatic scan(input logic [31:0] nibs, input int first, input int last, input int hold);
    for (int k = first; k <= last; k++) begin
      an = 3'(k);
      dat = nibs[k*4 +: 4];
      repeat (hold) step();
    end
  endtask

  initial begin
    int n;
    do_reset();
    chk("reset_frame", frame_data, 32'h0);
    chk("reset_seen", {24'd0, digit_seen}, 32'h0);

    // Clean scan with the consumer always ready.
    ready = 1'b1;
    scan(32'h87654321, 0, 7, H);
    repeat (LAT) step();
    chk("clean_frame", obs_frame, 32'h87654321);
    chk("clean_pulses", obs_valid, 1);
    chk("clean_ovr", obs_ovr, 0);

`ifdef HEXPLAY_CAPTURE_FILTER_EN
    // A short-lived value on digit 3 must never reach the frame.
    do_reset();
    an = 3'd3; dat = 4'hA;
    repeat (10) step();
    dat = 4'h5;
    repeat (S + 4) step();
    chk("glitch_seen", {24'd0, digit_seen}, 32'h08);
    scan(32'h00000000, 0, 2, H);
    scan(32'h00000000, 4, 7, H);
    chk("glitch_frame", obs_frame, 32'h00005000);
`else
    // Without filtering, the frame completes 8 edges after an=0 is registered.
    do_reset();
    an = 3'd0; dat = 4'h1;
    step();
    n = 0;
    while (!frame_valid && n < 20) begin
      n++;
      if (n < 8) begin
        an = 3'(n); dat = 4'(n + 1);
      end
      step();
    end
    chk("nofilt_latency", n, 8);
`endif

    // Backpressure: second complete frame is dropped.
    do_reset();
    ready = 1'b0;
    scan(32'h87654321, 0, 7, H);
    scan(32'h89ABCDEF, 0, 7, H);
    repeat (LAT) step();
    chk("bp_frame", frame_data, 32'h87654321);
    chk("bp_valid", {31'd0, frame_valid}, 32'd1);
    chk("bp_ovr", obs_ovr, 1);

    // Ready coincides with the completing edge: reload, not overrun.
    do_reset();
    ready = 1'b0;
    scan(32'h87654321, 0, 7, H);
    scan(32'h89ABCDEF, 0, 6, H);
    an = 3'd7; dat = 4'h8;
    repeat (LAT - 1) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("sim_frame", frame_data, 32'h89ABCDEF);
    chk("sim_valid", {31'd0, frame_valid}, 32'd1);
    step();
    chk("sim_hold", {31'd0, frame_valid}, 32'd1);
    chk("sim_ovr", obs_ovr, 0);

    // Reset mid-frame discards the partial frame.
    do_reset();
    ready = 1'b1;
    scan(32'h87654321, 0, 4, H);
    do_reset();
    chk("rst_seen", {24'd0, digit_seen}, 32'h0);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    scan(32'h87654321, 5, 7, H);
    repeat (LAT) step();
    chk("rst_partial", obs_valid, 0);
    scan(32'h87654321, 0, 4, H);
    repeat (LAT) step();
    chk("rst_full", obs_valid, 1);

    // Random scans, random holds (including sub-threshold glitches), random ready.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int hold;
      an  = 3'($urandom_range(0, 7));
      dat = 4'($urandom_range(0, 15));
`ifdef HEXPLAY_CAPTURE_FILTER_EN
      hold = $urandom_range(1, 2 * S);
`else
      hold = $urandom_range(1, 3);
`endif
      for (int c = 0; c < hold; c++) begin
        ready = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
